// File: rtl/word_packer.sv
// word_packer: collects K words of N bits into one packed group and holds
// the group until the downstream CSA adder takes it.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid/in_ready     upstream word handshake, word on in_word
//   in_last               ends a group early (WORD_PACKER_FLUSH_EN only)
//   out_valid/out_ready   downstream group handshake
//   out_words             packed group, word i at [(i+1)*N-1 : i*N]
//   word_count            words written into the current group
//
// Optional feature: define WORD_PACKER_FLUSH_EN to honour in_last.
module word_packer #(
    parameter int N  = 8,
    parameter int K  = 10,
    parameter int CW = $clog2(K + 1)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_word,
    input  logic           in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] out_words,
    output logic [CW-1:0]  word_count
);

    typedef enum logic {
        FILL,
        HOLD
    } state_t;

    state_t        state;
    logic [N-1:0]  words [K];
    logic [CW-1:0] count;
    logic          accept;
    logic          last_word;

    // Handshake flags decode the state register only.
    assign in_ready  = (state == FILL);
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

`ifdef WORD_PACKER_FLUSH_EN
    assign last_word = (count == CW'(K - 1)) || in_last;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign last_word      = (count == CW'(K - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            count <= '0;
            for (int i = 0; i < K; i++) begin
                words[i] <= '0;
            end
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        // Slot select by compare avoids an index
                        // whose width differs from the array range.
                        for (int i = 0; i < K; i++) begin
                            if (count == CW'(i)) begin
                                words[i] <= in_word;
                            end
                        end
                        count <= count + CW'(1);
                        if (last_word) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= FILL;
                        count <= '0;
                        for (int i = 0; i < K; i++) begin
                            words[i] <= '0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    for (genvar g = 0; g < K; g++) begin : g_pack
        assign out_words[g*N +: N] = words[g];
    end

    assign word_count = count;

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the packer (N=8, K=4).
module tb_word_packer;

    localparam int N  = 8;
    localparam int K  = 4;
    localparam int CW = $clog2(K + 1);

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_word;
    logic           in_last;
    logic           out_valid;
    logic           out_ready;
    logic [N*K-1:0] out_words;
    logic [CW-1:0]  word_count;

    int vectors = 0;
    int errors  = 0;

    // Reference model: words accepted into the current group, and
    // whether that group is complete and being presented.
    logic [N-1:0] grp[$];
    bit           full;

    word_packer #(.N(N), .K(K)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_words  (out_words),
        .word_count (word_count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [N*K-1:0] model_pack();
        logic [N*K-1:0] p = '0;
        for (int i = 0; i < grp.size(); i++) begin
            p[i*N +: N] = grp[i];
        end
        return p;
    endfunction

    task automatic model_edge(input bit r, input bit v,
                              input logic [N-1:0] w,
                              input bit l, input bit o);
        if (r) begin
            grp.delete();
            full = 0;
        end else if (full) begin
            if (o) begin
                grp.delete();
                full = 0;
            end
        end else if (v) begin
            grp.push_back(w);
            if (grp.size() == K) full = 1;
`ifdef WORD_PACKER_FLUSH_EN
            if (l) full = 1;
`endif
        end
    endtask

    // Drive one cycle, advance the model, sample 1 ns after the edge.
    task automatic tick(input bit r, input bit v,
                        input logic [N-1:0] w,
                        input bit l, input bit o);
        rst       = r;
        in_valid  = v;
        in_word   = w;
        in_last   = l;
        out_ready = o;
        @(posedge clk);
        model_edge(r, v, w, l, o);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 8'h00, 0, 0);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: in_ready=%b out_valid=%b want 1/0",
                     in_ready, out_valid);
        end
        vectors++;
        if (word_count !== 0 || out_words !== 0) begin
            errors++;
            $display("FAIL reset_regs: count=%0d words=%h want 0/0",
                     word_count, out_words);
        end
        tick(0, 0, 8'h00, 0, 0);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_full_group();
        logic [N-1:0] w[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) tick(0, 1, w[i], 0, 1);
        vectors++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_flags: out_valid=%b in_ready=%b want 1/0",
                     out_valid, in_ready);
        end
        vectors++;
        if (out_words !== 32'h44332211 || word_count !== 4) begin
            errors++;
            $display("FAIL full_data: words=%h count=%0d want 44332211/4",
                     out_words, word_count);
        end
        tick(0, 0, 8'h00, 0, 1);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
            word_count !== 0 || out_words !== 0) begin
            errors++;
            $display("FAIL full_after: rdy=%b vld=%b cnt=%0d w=%h want 1/0/0/0",
                     in_ready, out_valid, word_count, out_words);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] w[4] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        for (int i = 0; i < 4; i++) tick(0, 1, w[i], 0, 0);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_words !== 32'h8D7C6B5A || word_count !== 4) begin
                errors++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b w=%h cnt=%0d want 1/0/8d7c6b5a/4",
                         c, out_valid, in_ready, out_words, word_count);
            end
            tick(0, 1, 8'hEE, 1, 0);
        end
        vectors++;
        if (out_words !== 32'h8D7C6B5A) begin
            errors++;
            $display("FAIL bp_stable: words=%h want 8d7c6b5a", out_words);
        end
        tick(0, 1, 8'hEE, 0, 1);
        vectors++;
        if (in_ready !== 1'b1 || word_count !== 0 || out_words !== 0) begin
            errors++;
            $display("FAIL bp_release: rdy=%b cnt=%0d w=%h want 1/0/0",
                     in_ready, word_count, out_words);
        end
    endtask

    task automatic test_gaps();
        for (int i = 1; i <= 4; i++) begin
            tick(0, 1, 8'(i), 0, 1);
            if (i < 4) begin
                tick(0, 0, 8'hFF, 0, 1);
                tick(0, 0, 8'hFF, 0, 1);
            end
        end
        vectors++;
        if (out_valid !== 1'b1 || out_words !== 32'h04030201 ||
            word_count !== 4) begin
            errors++;
            $display("FAIL gaps: vld=%b w=%h cnt=%0d want 1/04030201/4",
                     out_valid, out_words, word_count);
        end
        tick(0, 0, 8'h00, 0, 1);
    endtask

    task automatic test_reset_mid_fill();
        tick(0, 1, 8'hC1, 0, 1);
        tick(0, 1, 8'hC2, 0, 1);
        vectors++;
        if (word_count !== 2 || out_words !== 32'h0000C2C1) begin
            errors++;
            $display("FAIL mid_partial: cnt=%0d w=%h want 2/0000c2c1",
                     word_count, out_words);
        end
        tick(1, 1, 8'hC3, 0, 1);
        vectors++;
        if (word_count !== 0 || out_words !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: cnt=%0d w=%h rdy=%b want 0/0/1",
                     word_count, out_words, in_ready);
        end
        for (int i = 0; i < 4; i++) tick(0, 1, 8'hD0 + 8'(i), 0, 1);
        vectors++;
        if (out_valid !== 1'b1 || out_words !== 32'hD3D2D1D0) begin
            errors++;
            $display("FAIL mid_clean: vld=%b w=%h want 1/d3d2d1d0",
                     out_valid, out_words);
        end
        tick(0, 0, 8'h00, 0, 1);
    endtask

    task automatic test_flush();
        tick(0, 1, 8'hAA, 0, 1);
        tick(0, 1, 8'hBB, 1, 1);
`ifdef WORD_PACKER_FLUSH_EN
        vectors++;
        if (out_valid !== 1'b1 || out_words !== 32'h0000BBAA ||
            word_count !== 2) begin
            errors++;
            $display("FAIL flush_on: vld=%b w=%h cnt=%0d want 1/0000bbaa/2",
                     out_valid, out_words, word_count);
        end
`else
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || word_count !== 2) begin
            errors++;
            $display("FAIL flush_off: rdy=%b vld=%b cnt=%0d want 1/0/2",
                     in_ready, out_valid, word_count);
        end
`endif
        tick(1, 0, 8'h00, 0, 0);
        // in_last on the K-th word behaves as a normal full group.
        for (int i = 1; i <= 4; i++) tick(0, 1, 8'(i), i == 4, 1);
        vectors++;
        if (out_valid !== 1'b1 || out_words !== 32'h04030201 ||
            word_count !== 4) begin
            errors++;
            $display("FAIL flush_kth: vld=%b w=%h cnt=%0d want 1/04030201/4",
                     out_valid, out_words, word_count);
        end
        tick(0, 0, 8'h00, 0, 1);
    endtask

    task automatic test_back_to_back();
        logic [N*K-1:0] got[$];
        int idx   = 0;
        int zeros = 0;
        bit rdy;
        for (int c = 0; c < 10; c++) begin
            if (out_valid === 1'b1) got.push_back(out_words);
            if (in_ready !== 1'b1) zeros++;
            rdy = in_ready;
            tick(0, idx < 8, 8'hA0 + 8'(idx), 0, 1);
            if (rdy && idx < 8) idx++;
        end
        vectors++;
        if (got.size() != 2 || idx != 8) begin
            errors++;
            $display("FAIL b2b_count: groups=%0d words=%0d want 2/8",
                     got.size(), idx);
        end else begin
            vectors++;
            if (got[0] !== 32'hA3A2A1A0 || got[1] !== 32'hA7A6A5A4) begin
                errors++;
                $display("FAIL b2b_order: g0=%h g1=%h want a3a2a1a0/a7a6a5a4",
                         got[0], got[1]);
            end
        end
        vectors++;
        if (zeros != 2) begin
            errors++;
            $display("FAIL b2b_gap: in_ready low %0d cycles want 2 (one per group)",
                     zeros);
        end
        vectors++;
        if (in_ready !== 1'b1 || word_count !== 0) begin
            errors++;
            $display("FAIL b2b_end: rdy=%b cnt=%0d want 1/0",
                     in_ready, word_count);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(39) == 0, $urandom_range(3) != 0,
                 8'($urandom), $urandom_range(4) == 0,
                 $urandom_range(2) != 0);
            vectors++;
            if (in_ready !== !full || out_valid !== full) begin
                errors++;
                $display("FAIL rnd_flags[%0d]: rdy=%b vld=%b want %b/%b",
                         c, in_ready, out_valid, !full, full);
            end
            vectors++;
            if (word_count !== CW'(grp.size())) begin
                errors++;
                $display("FAIL rnd_count[%0d]: cnt=%0d want %0d",
                         c, word_count, grp.size());
            end
            vectors++;
            if (out_words !== model_pack()) begin
                errors++;
                $display("FAIL rnd_words[%0d]: w=%h want %h",
                         c, out_words, model_pack());
            end
        end
    endtask

    initial begin
        rst       = 1;
        in_valid  = 0;
        in_word   = '0;
        in_last   = 0;
        out_ready = 0;
        full      = 0;
        test_reset();
        test_full_group();
        test_backpressure();
        test_gaps();
        test_reset_mid_fill();
        test_flush();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
